segment_press_driver: RTL and testbench

SEGMENT_PRESS_DRIVER -- requirements
Module: segment_press_driver

---
 rtl/segment_press_driver.sv | 171 +++++++++++++++++
 tb/tb_segment_press_driver.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/segment_press_driver.sv
// segment_press_driver
//   Drives the +/- buttons of a 7-segment display until it shows a requested digit.
//   The displayed pattern is registered once and decoded. A small FSM then presses
//   toward the target one step at a time, and re-checks after each press/gap window.
//
// Ports
//   clk          sole clock, rising edge
//   rst          asynchronous active-high reset
//   start        one-cycle command strobe, honoured only while idle
//   target[3:0]  requested digit, latched when a start is accepted
//   segment[6:0] active-low pattern read back from the display (bit 6 = g .. bit 0 = a)
//   button_plus  increment press request
//   button_minus decrement press request
//   digit[3:0]   last legally decoded digit
//   digit_valid  registered pattern is a legal digit
//   busy         command in progress
//   done         one-cycle pulse, display reached target
//   error        one-cycle pulse, command rejected or aborted
module segment_press_driver #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned MAX_PRESSES = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] target,
  input  logic [6:0] segment,
  output logic       button_plus,
  output logic       button_minus,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned TimerMax = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned TimerW   = (TimerMax > 1) ? $clog2(TimerMax) : 1;
  localparam int unsigned CountW   = (MAX_PRESSES > 0) ? $clog2(MAX_PRESSES + 1) : 1;

  localparam logic [TimerW-1:0] HoldLast = TimerW'(HOLD_CYCLES - 1);
  localparam logic [TimerW-1:0] GapLast  = TimerW'(GAP_CYCLES - 1);
  localparam logic [CountW-1:0] CountMax = CountW'(MAX_PRESSES);

  typedef enum logic [1:0] {StIdle, StCheck, StPress, StGap} state_e;

  state_e            state_q, state_d;
  logic [6:0]        seg_q;
  logic [3:0]        digit_hold_q;
  logic [3:0]        target_q, target_d;
  logic [CountW-1:0] cnt_q, cnt_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              dir_q, dir_d;      // 1: plus, 0: minus
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic [3:0]        dec_digit;
  logic              dec_valid;

  // Decode the registered pattern only; illegal patterns keep the last good digit.
  always_comb begin
    dec_valid = 1'b1;
    dec_digit = 4'd0;
    unique case (seg_q)
      7'b1000000: dec_digit = 4'd0;
      7'b1111001: dec_digit = 4'd1;
      7'b0100100: dec_digit = 4'd2;
      7'b0110000: dec_digit = 4'd3;
      7'b0011001: dec_digit = 4'd4;
      7'b0010010: dec_digit = 4'd5;
      7'b0000010: dec_digit = 4'd6;
      7'b1111000: dec_digit = 4'd7;
      7'b0000000: dec_digit = 4'd8;
      7'b0011000: dec_digit = 4'd9;
      default:    dec_valid = 1'b0;
    endcase
  end

  assign digit_valid = dec_valid;
  assign digit       = dec_valid ? dec_digit : digit_hold_q;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    timer_d  = timer_q;
    dir_d    = dir_q;
    done_d   = 1'b0;
    error_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (target <= 4'd9) begin
            target_d = target;
            cnt_d    = '0;
            state_d  = StCheck;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      StCheck: begin
        if (!digit_valid) begin
          error_d = 1'b1;
          state_d = StIdle;
        end else if (digit == target_q) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (cnt_q == CountMax) begin
          error_d = 1'b1;
          state_d = StIdle;
        end else begin
          dir_d   = (digit < target_q);
          cnt_d   = cnt_q + CountW'(1);
          timer_d = '0;
          state_d = StPress;
        end
      end
      StPress: begin
        if (timer_q == HoldLast) begin
          timer_d = '0;
          state_d = StGap;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StGap: begin
        if (timer_q == GapLast) begin
          timer_d = '0;
          state_d = StCheck;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      seg_q        <= 7'b1111111;
      digit_hold_q <= 4'd0;
      target_q     <= 4'd0;
      cnt_q        <= '0;
      timer_q      <= '0;
      dir_q        <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      seg_q        <= segment;
      digit_hold_q <= digit;
      target_q     <= target_d;
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
      dir_q        <= dir_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  // Buttons decode straight from the state register so reset drops them at once.
  assign button_plus  = (state_q == StPress) &&  dir_q;
  assign button_minus = (state_q == StPress) && !dir_q;
  assign busy         = (state_q != StIdle);
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_segment_press_driver.sv
module tb_segment_press_driver;

  localparam int Hold = 4;
  localparam int Gap  = 4;
  localparam int MaxP = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] target;
  logic [6:0] segment;
  logic       button_plus, button_minus, digit_valid, busy, done, error;
  logic [3:0] digit;

  segment_press_driver #(
    .HOLD_CYCLES(Hold),
    .GAP_CYCLES (Gap),
    .MAX_PRESSES(MaxP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .target      (target),
    .segment     (segment),
    .button_plus (button_plus),
    .button_minus(button_minus),
    .digit       (digit),
    .digit_valid (digit_valid),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  logic [6:0] enc [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: command as a schedule of cycle numbers.
  bit         m_active;
  bit         m_dir;
  int         m_tgt, presses, chk_cyc, press_lo, press_hi, done_at, err_at, hold_digit;
  logic [6:0] seg_reg;
  bit         rst_prev;

  // Display model and observation counters.
  int disp_val;
  bit freeze, blank, plus_prev, minus_prev;
  int plus_pulses, minus_pulses, done_cnt, err_cnt, done_cyc, err_cyc, st_cyc;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_cycle();
    bit e_valid, e_busy, e_plus, e_minus, e_done, e_err, in_rst;
    int e_digit, dec;
    e_valid = 0; e_busy = 0; e_plus = 0; e_minus = 0; e_done = 0; e_err = 0;
    e_digit = 0; dec = 0;
    in_rst  = rst || rst_prev;
    if (in_rst) begin
      m_active = 0; done_at = -1; err_at = -1; press_lo = 1; press_hi = 0; hold_digit = 0;
    end else begin
      for (int i = 0; i < 10; i++) if (seg_reg == enc[i]) begin e_valid = 1; dec = i; end
      e_digit = e_valid ? dec : hold_digit;
      e_busy  = m_active;
      e_plus  = m_active && cyc >= press_lo && cyc <= press_hi && m_dir;
      e_minus = m_active && cyc >= press_lo && cyc <= press_hi && !m_dir;
      e_done  = (cyc == done_at);
      e_err   = (cyc == err_at);
    end
    chk("button_plus", int'(button_plus), int'(e_plus));
    chk("button_minus", int'(button_minus), int'(e_minus));
    chk("busy", int'(busy), int'(e_busy));
    chk("done", int'(done), int'(e_done));
    chk("error", int'(error), int'(e_err));
    chk("digit_valid", int'(digit_valid), int'(e_valid));
    chk("digit", int'(digit), e_digit);

    if (button_plus && !plus_prev) plus_pulses++;
    if (button_minus && !minus_prev) minus_pulses++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (error) begin err_cnt++; err_cyc = cyc; end

    if (!in_rst) begin
      hold_digit = e_digit;
      if (m_active && cyc == chk_cyc) begin
        if (!e_valid) begin
          err_at = cyc + 1; m_active = 0;
        end else if (e_digit == m_tgt) begin
          done_at = cyc + 1; m_active = 0;
        end else if (presses == MaxP) begin
          err_at = cyc + 1; m_active = 0;
        end else begin
          m_dir    = (e_digit < m_tgt);
          presses++;
          press_lo = cyc + 1;
          press_hi = cyc + Hold;
          chk_cyc  = cyc + Hold + Gap + 1;
        end
      end
    end
    if (!rst && start && !e_busy) begin
      if (target <= 4'd9) begin
        m_active = 1; chk_cyc = cyc + 1; m_tgt = int'(target); presses = 0;
      end else begin
        err_at = cyc + 1;
      end
    end

    // Display: one step per button rising edge, clamped to 0..9.
    if (!freeze) begin
      if (button_plus && !plus_prev && disp_val < 9) disp_val++;
      if (button_minus && !minus_prev && disp_val > 0) disp_val--;
    end
    plus_prev  = button_plus;
    minus_prev = button_minus;
    segment    = blank ? 7'b1111111 : enc[disp_val];
    seg_reg    = rst ? 7'b1111111 : segment;
    rst_prev   = rst;
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic clear_stats();
    plus_pulses = 0; minus_pulses = 0; done_cnt = 0; err_cnt = 0; done_cyc = -1; err_cyc = -1;
  endtask

  // Load the display, issue one command and wait (bounded) for its outcome.
  task automatic run_cmd(input int init_val, input bit frz, input int tgt);
    int n;
    disp_val = init_val;
    freeze   = frz;
    repeat (3) step();
    clear_stats();
    start  = 1'b1;
    target = 4'(tgt);
    st_cyc = cyc;
    step();
    start  = 1'b0;
    n = 0;
    while (done_cnt + err_cnt == 0 && n < 400) begin step(); n++; end
    chk("outcome_timeout", int'(n < 400), 1);
    step();
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; target = 4'd0; segment = 7'b1111111;
    seg_reg = 7'b1111111; rst_prev = 1'b1; m_active = 0; m_dir = 0; m_tgt = 0; presses = 0;
    chk_cyc = -1; press_lo = 1; press_hi = 0; done_at = -1; err_at = -1; hold_digit = 0;
    disp_val = 0; freeze = 0; blank = 0; plus_prev = 0; minus_prev = 0;
    clear_stats();
    st_cyc = 0;
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();

    // 3 -> 5 with a start injected mid-command that must be ignored.
    disp_val = 3;
    repeat (3) step();
    clear_stats();
    start = 1'b1; target = 4'd5; st_cyc = cyc;
    step();
    start = 1'b0;
    repeat (5) step();
    start = 1'b1; target = 4'd0;
    step();
    start = 1'b0;
    n = 0;
    while (done_cnt + err_cnt == 0 && n < 100) begin step(); n++; end
    chk("up_plus_pulses", plus_pulses, 2);
    chk("up_minus_pulses", minus_pulses, 0);
    chk("up_done_cnt", done_cnt, 1);
    chk("up_err_cnt", err_cnt, 0);
    chk("up_done_latency", done_cyc - st_cyc, 20);
    chk("up_final_digit", int'(digit), 5);
    step();

    run_cmd(7, 0, 2);
    chk("down_minus_pulses", minus_pulses, 5);
    chk("down_plus_pulses", plus_pulses, 0);
    chk("down_done_cnt", done_cnt, 1);

    run_cmd(4, 0, 4);
    chk("same_done_latency", done_cyc - st_cyc, 2);
    chk("same_presses", plus_pulses + minus_pulses, 0);

    run_cmd(4, 0, 12);
    chk("bad_err_latency", err_cyc - st_cyc, 1);
    chk("bad_presses", plus_pulses + minus_pulses, 0);
    chk("bad_done_cnt", done_cnt, 0);

    run_cmd(0, 1, 9);
    chk("budget_plus_pulses", plus_pulses, 12);
    chk("budget_err_latency", err_cyc - st_cyc, 110);
    chk("budget_done_cnt", done_cnt, 0);
    freeze = 0;

    // Blank display mid-command: the next check must abort.
    disp_val = 0;
    repeat (3) step();
    clear_stats();
    start = 1'b1; target = 4'd9; st_cyc = cyc;
    step();
    start = 1'b0;
    repeat (5) step();
    blank = 1;
    n = 0;
    while (err_cnt + done_cnt == 0 && n < 50) begin step(); n++; end
    chk("blank_err_latency", err_cyc - st_cyc, 11);
    chk("blank_plus_pulses", plus_pulses, 1);
    chk("blank_done_cnt", done_cnt, 0);
    blank = 0;
    repeat (3) step();

    // Reset during the second press of 3 -> 5.
    disp_val = 3;
    repeat (3) step();
    clear_stats();
    start = 1'b1; target = 4'd5;
    step();
    start = 1'b0;
    n = 0;
    while (!(plus_pulses == 2 && button_plus) && n < 50) begin step(); n++; end
    chk("second_press_seen", int'(plus_pulses == 2 && button_plus), 1);
    rst = 1'b1;
    #1;
    chk("rst_plus_dropped", int'(button_plus), 0);
    chk("rst_busy_dropped", int'(busy), 0);
    repeat (2) step();
    rst = 1'b0;
    repeat (30) step();
    chk("rst_no_resume_pulses", plus_pulses, 2);
    chk("rst_no_resume_done", done_cnt + err_cnt, 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      start = 1'b0;
      blank = 0;
      if (!busy && $urandom_range(19, 0) == 0) begin
        disp_val = $urandom_range(9, 0);
        freeze   = ($urandom_range(5, 0) == 0);
      end
      if ($urandom_range(7, 0) == 0) begin
        start  = 1'b1;
        target = 4'($urandom_range(15, 0));
      end
      if ($urandom_range(199, 0) == 0) blank = 1;
      if ($urandom_range(499, 0) == 0) rst = 1'b1;
      step();
      rst = 1'b0;
    end
    start = 1'b0;
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
